// File: rtl/pipe_pkg.sv
// Shared state and occupancy encoding for the skid-buffered pipeline stage.
package pipe_pkg;

  localparam int unsigned OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [OCC_W-1:0] OCC_EMPTY = 2'd0;
  localparam logic [OCC_W-1:0] OCC_ONE   = 2'd1;
  localparam logic [OCC_W-1:0] OCC_FULL  = 2'd2;

  // Number of held entries for a given state.
  function automatic logic [OCC_W-1:0] occ_of(input state_e s);
    case (s)
      ONE:     return OCC_ONE;
      FULL:    return OCC_FULL;
      default: return OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Upstream/downstream handshake bundle of the skid stage.
interface pipe_stage_skid_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8
);
  import pipe_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [OCC_W-1:0]  occupancy;

  // Environment side: offers entries and accepts results.
  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, occupancy
  );

  // Stage side.
  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, occupancy
  );

endinterface

// File: rtl/pipe_entry.sv
// One held entry: valid flag, payload and control bits with load/clear enables.
module pipe_entry #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic              i_clr,
  input  logic              i_clr_data,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  // Clearing always drops control; payload survives unless explicitly zeroed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      if (i_clr_data) r_data <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_ctrl  <= i_ctrl;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline stage: registered in_ready, one-cycle latency, full throughput.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CTRL_W   = 8,
  parameter bit          CLR_DATA = 1'b0
) (
  input logic              clk,
  input logic              reset_n,
  input logic              flush,
  pipe_stage_skid_if.slave bus
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_in_ready;
  logic [OCC_W-1:0] r_occ;
  logic             w_in_ready_nxt;
  logic [OCC_W-1:0] w_occ_nxt;

  logic w_in_xfer;
  logic w_out_xfer;
  logic w_clr_data;

  logic              w_main_load, w_main_clr, w_main_valid;
  logic [DATA_W-1:0] w_main_src_data, w_main_data;
  logic [CTRL_W-1:0] w_main_src_ctrl, w_main_ctrl;
  logic              w_skid_load, w_skid_clr, w_skid_valid;
  logic [DATA_W-1:0] w_skid_data;
  logic [CTRL_W-1:0] w_skid_ctrl;

  assign w_in_xfer  = bus.in_valid && r_in_ready;
  assign w_out_xfer = w_main_valid && bus.out_ready;
  assign w_clr_data = flush && CLR_DATA;

  // State register; in_ready and occupancy are registered alongside it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
      r_occ      <= OCC_EMPTY;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= w_in_ready_nxt;
      r_occ      <= w_occ_nxt;
    end
  end

  // Next state; flush wins over any transfer.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY:   if (w_in_xfer) w_state_nxt = ONE;
        ONE: begin
          if (w_in_xfer && !w_out_xfer)      w_state_nxt = FULL;
          else if (!w_in_xfer && w_out_xfer) w_state_nxt = EMPTY;
        end
        FULL:    if (w_out_xfer) w_state_nxt = ONE;
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // Entry enables and next values of the registered status outputs.
  always_comb begin
    w_main_load    = 1'b0;
    w_main_clr     = flush;
    w_skid_load    = 1'b0;
    w_skid_clr     = flush;
    w_in_ready_nxt = (w_state_nxt != FULL);
    w_occ_nxt      = occ_of(w_state_nxt);
    if (!flush) begin
      case (r_state)
        EMPTY: w_main_load = w_in_xfer;
        ONE: begin
          w_main_load = w_in_xfer && w_out_xfer;
          w_main_clr  = w_out_xfer && !w_in_xfer;
          w_skid_load = w_in_xfer && !w_out_xfer;
        end
        FULL: begin
          w_main_load = w_out_xfer;
          w_skid_clr  = w_out_xfer;
        end
        default: begin
        end
      endcase
    end
  end

  // Main refills from the skid whenever the skid holds the older entry.
  assign w_main_src_data = w_skid_valid ? w_skid_data : bus.in_data;
  assign w_main_src_ctrl = w_skid_valid ? w_skid_ctrl : bus.in_ctrl;

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_main_load),
    .i_clr      (w_main_clr),
    .i_clr_data (w_clr_data),
    .i_data     (w_main_src_data),
    .i_ctrl     (w_main_src_ctrl),
    .o_valid    (w_main_valid),
    .o_data     (w_main_data),
    .o_ctrl     (w_main_ctrl)
  );

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_skid_load),
    .i_clr      (w_skid_clr),
    .i_clr_data (w_clr_data),
    .i_data     (bus.in_data),
    .i_ctrl     (bus.in_ctrl),
    .o_valid    (w_skid_valid),
    .o_data     (w_skid_data),
    .o_ctrl     (w_skid_ctrl)
  );

  assign bus.in_ready  = r_in_ready;
  assign bus.occupancy = r_occ;
  assign bus.out_valid = w_main_valid;
  assign bus.out_data  = w_main_data;
  assign bus.out_ctrl  = w_main_valid ? w_main_ctrl : '0;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: directed scenarios followed by a random handshake soak.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  c;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n;
  logic flush;

  int          n_chk = 0;
  int          n_err = 0;
  int          pre_cnt = 0;
  logic        chk_en = 1'b0;
  logic [31:0] last_d = '0;
  ent_t        q[$];

  pipe_stage_skid_if #(.DATA_W(32), .CTRL_W(8)) bus ();

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .CLR_DATA(1'b0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic [7:0] c,
                      input logic rdy, input logic fl);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_ctrl   = c;
    bus.out_ready = rdy;
    flush         = fl;
    @(posedge clk);
    #1;
  endtask

  // Monitor: checks what the stage presents and pops on each output transfer.
  always @(negedge clk) begin
    pre_cnt = q.size();
    if (chk_en) begin
      chk("in_ready", 32'(bus.in_ready), 32'(pre_cnt != 2));
      chk("occupancy", 32'(bus.occupancy), 32'(pre_cnt));
      chk("out_valid", 32'(bus.out_valid), 32'(pre_cnt != 0));
      if (pre_cnt != 0) begin
        last_d = q[0].d;
        chk("out_data", bus.out_data, q[0].d);
        chk("out_ctrl", 32'(bus.out_ctrl), 32'(q[0].c));
        if (reset_n && bus.out_ready) void'(q.pop_front());
      end else begin
        chk("bubble_ctrl", 32'(bus.out_ctrl), 32'h0);
        chk("hold_data", bus.out_data, last_d);
      end
    end
  end

  // Issue side: records accepted entries, runs after the monitor each cycle.
  always @(negedge clk) begin
    #1;
    if (!reset_n) begin
      q.delete();
      last_d = '0;
    end else if (flush) begin
      q.delete();
    end else if (bus.in_valid && pre_cnt != 2) begin
      q.push_back('{d: bus.in_data, c: bus.in_ctrl});
    end
  end

  initial begin
    logic        v, r, f;
    logic [31:0] d;
    logic [7:0]  c;

    reset_n       = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h1;
    bus.in_ctrl   = 8'h11;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_occ", 32'(bus.occupancy), 32'h0);
    chk("rst_out_ctrl", 32'(bus.out_ctrl), 32'h0);
    chk("rst_out_data", bus.out_data, 32'h0);

    // First edge out of reset accepts the offered entry.
    reset_n = 1'b1;
    step(1'b1, 32'h1, 8'h11, 1'b0, 1'b0);
    chk("first_valid", 32'(bus.out_valid), 32'h1);
    chk("first_data", bus.out_data, 32'h1);
    step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);

    // Streaming at one entry per cycle.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'(32'h10 + i), 8'(i + 1), 1'b1, 1'b0);
      chk("stream_data", bus.out_data, 32'(32'h10 + i));
      chk("stream_occ", 32'(bus.occupancy), 32'h1);
    end
    step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
    chk("stream_drained", 32'(bus.out_valid), 32'h0);

    // Backpressure fills the skid; third entry held off.
    step(1'b1, 32'hA0, 8'h20, 1'b0, 1'b0);
    step(1'b1, 32'hA1, 8'h21, 1'b0, 1'b0);
    step(1'b1, 32'hA2, 8'h22, 1'b0, 1'b0);
    chk("bp_occ", 32'(bus.occupancy), 32'h2);
    chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
    chk("bp_head", bus.out_data, 32'hA0);
    step(1'b1, 32'hA2, 8'h22, 1'b1, 1'b0);
    chk("bp_second", bus.out_data, 32'hA1);
    chk("bp_occ_one", 32'(bus.occupancy), 32'h1);
    step(1'b1, 32'hA2, 8'h22, 1'b1, 1'b0);
    chk("bp_third", bus.out_data, 32'hA2);
    step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
    chk("bp_drained", 32'(bus.out_valid), 32'h0);

    // Flush while full with a new entry offered.
    step(1'b1, 32'hD0, 8'h30, 1'b0, 1'b0);
    step(1'b1, 32'hD1, 8'h31, 1'b0, 1'b0);
    step(1'b1, 32'hB0, 8'h3B, 1'b0, 1'b1);
    chk("flush_occ", 32'(bus.occupancy), 32'h0);
    chk("flush_valid", 32'(bus.out_valid), 32'h0);
    chk("flush_ctrl", 32'(bus.out_ctrl), 32'h0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'h1);
    step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
    chk("flush_no_b0", 32'(bus.out_valid), 32'h0);

    // Flush coinciding with an output transfer in ONE.
    step(1'b1, 32'hE0, 8'h40, 1'b1, 1'b0);
    step(1'b1, 32'hB1, 8'h41, 1'b1, 1'b1);
    chk("flush1_occ", 32'(bus.occupancy), 32'h0);
    step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);

    // Control gated to zero in a bubble, payload held.
    step(1'b1, 32'hC0, 8'hFF, 1'b1, 1'b0);
    step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
    chk("bubble_valid", 32'(bus.out_valid), 32'h0);
    chk("bubble_ctrl_dir", 32'(bus.out_ctrl), 32'h0);
    chk("bubble_data_dir", bus.out_data, 32'hC0);

    // Random handshake and flush soak.
    for (int i = 0; i < 10000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 31) == 0);
      d = $urandom;
      c = 8'($urandom);
      step(v, d, c, r, f);
    end
    repeat (4) step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
    chk("final_occ", 32'(bus.occupancy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
